n64_vmux: RTL and testbench

Multiplexes parallel pixel words (4 sync bits + 7-bit R/G/B) onto the N64 serial video bus: one nDSYNC-marked sync nibble followed by red, green and blue on four consecutive VCLK cycles. It is the transmit-side counterpart of the video demux. It sits behind test-pattern and OSD sources, and drives the bus that the demux and the downstream DAC path consume in loopback and bench setups.

---
 rtl/n64_vmux_pkg.sv | 40 ++++
 rtl/n64_vmux_if.sv | 12 +
 rtl/n64_vmux_fifo.sv | 59 +++++
 rtl/n64_vmux.sv | 90 +++++++++
 tb/tb_n64_vmux.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/n64_vmux_pkg.sv
// Shared types and constants for the N64 video multiplexer: pixel layout,
// blank pixel, bus phase encodings and the colour-depth mask.
package n64_vmux_pkg;

  localparam int VDATA_W = 25;
  localparam int COLOR_W = 7;

  // Sync bits are active low; the nibble order matches the bus sync nibble.
  typedef struct packed {
    logic nvsync;
    logic nclamp;
    logic nhsync;
    logic ncsync;
  } sync_t;

  typedef struct packed {
    sync_t              sync;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pixel_t;

  // Inserted when the buffer runs dry: all sync lines idle high, black colour.
  localparam pixel_t BLANK_PIXEL = pixel_t'({4'hF, 21'h0});

  // Value of the phase counter before an edge; the name is what that edge emits.
  typedef enum logic [1:0] {
    PH_RED   = 2'd0,
    PH_GREEN = 2'd1,
    PH_BLUE  = 2'd2,
    PH_SYNC  = 2'd3
  } phase_e;

  // 15-bit mode drops the two colour LSBs; full mode passes the value through.
  function automatic logic [COLOR_W-1:0] mask_color(input logic [COLOR_W-1:0] c,
                                                    input logic               full);
    return full ? c : {c[COLOR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/n64_vmux_if.sv
// Pixel source handshake: a transfer happens when valid and ready are both
// high at a VCLK edge.
interface n64_vmux_if;
  import n64_vmux_pkg::*;

  logic [VDATA_W-1:0] pix_data_i;
  logic               pix_valid_i;
  logic               pix_ready_o;

  modport master (output pix_data_i, output pix_valid_i, input pix_ready_o);
  modport slave  (input pix_data_i, input pix_valid_i, output pix_ready_o);
endinterface

// File: rtl/n64_vmux_fifo.sv
// Small synchronous show-ahead FIFO: dout always presents the head entry.
// Push is ignored when full and pop is ignored when empty.
module n64_vmux_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 25
) (
  input  logic             VCLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; entries are only ever read after being written.
  // NOTE: the data array is deliberately left out of reset -- validity is
  // tracked by count, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge VCLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/n64_vmux.sv
// N64 video bus transmitter: serialises buffered parallel pixels into a
// sync nibble (nDSYNC low) followed by red, green and blue on VCLK.
module n64_vmux
  import n64_vmux_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int UCNT_W     = 8
) (
  input  logic               VCLK,
  input  logic               nRST,
  n64_vmux_if.slave          pix,
  input  logic               n15bit_mode_i,
  output logic               nDSYNC_o,
  output logic [COLOR_W-1:0] D_o,
  output logic [UCNT_W-1:0]  underrun_cnt_o
);

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               new_frame;
  logic               mode_full;
  logic [VDATA_W-1:0] fifo_dout;
  pixel_t             head;
  pixel_t             cur;
  pixel_t             next_cur;
  phase_e             p;

  assign pix.pix_ready_o = ~fifo_full;
  assign push            = pix.pix_valid_i & ~fifo_full;
  assign pop             = (p == PH_SYNC) & ~fifo_empty;
  assign head            = pixel_t'(fifo_dout);
  assign next_cur        = fifo_empty ? BLANK_PIXEL : head;
  // A frame starts on a vsync falling edge between consecutive emitted pixels;
  // cur still holds the previously emitted pixel at the sync edge.
  assign new_frame       = pop & ~head.sync.nvsync & cur.sync.nvsync;

  n64_vmux_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VDATA_W)
  ) u_fifo (
    .VCLK  (VCLK),
    .nRST  (nRST),
    .push  (push),
    .pop   (pop),
    .din   (pix.pix_data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Phase sequencer with registered bus outputs, pixel load, mode latch and
  // saturating underrun counter.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      p              <= PH_SYNC;
      cur            <= BLANK_PIXEL;
      mode_full      <= 1'b1;
      nDSYNC_o       <= 1'b1;
      D_o            <= '0;
      underrun_cnt_o <= '0;
    end else begin
      p <= phase_e'(p + 2'd1);
      unique case (p)
        PH_SYNC: begin
          cur      <= next_cur;
          nDSYNC_o <= 1'b0;
          D_o      <= {3'b000, next_cur.sync};
          if (new_frame) mode_full <= n15bit_mode_i;
          if (fifo_empty && (underrun_cnt_o != {UCNT_W{1'b1}}))
            underrun_cnt_o <= underrun_cnt_o + 1'b1;
        end
        PH_RED: begin
          nDSYNC_o <= 1'b1;
          D_o      <= mask_color(cur.r, mode_full);
        end
        PH_GREEN: begin
          nDSYNC_o <= 1'b1;
          D_o      <= mask_color(cur.g, mode_full);
        end
        PH_BLUE: begin
          nDSYNC_o <= 1'b1;
          D_o      <= mask_color(cur.b, mode_full);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_vmux.sv
// Self-checking bench for n64_vmux: a behavioural model predicts every
// output cycle into a scoreboard queue; directed checks cover the key cases.
module tb_n64_vmux;
  import n64_vmux_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [24:0] BLANK = 25'h1E00000;

  typedef struct {
    logic [24:0] data;
    logic        mode;
  } item_t;

  typedef struct {
    logic       nd;
    logic [6:0] d;
    int         ucnt;
    int         ucnt2;
    logic       nd2;
    logic [6:0] d2;
    logic       log_red;
  } exp_t;

  logic       VCLK = 1'b0;
  logic       rst_n;
  logic       mode_i;
  logic       nd_a, nd_b;
  logic [6:0] d_a, d_b;
  logic [7:0] ucnt_a;
  logic [1:0] ucnt_b;

  n64_vmux_if pix_a ();
  n64_vmux_if pix_b ();

  always #5 VCLK = ~VCLK;

  n64_vmux #(.FIFO_DEPTH(DEPTH), .UCNT_W(8)) dut (
    .VCLK(VCLK), .nRST(rst_n), .pix(pix_a), .n15bit_mode_i(mode_i),
    .nDSYNC_o(nd_a), .D_o(d_a), .underrun_cnt_o(ucnt_a)
  );

  // Idle second instance exercises counter saturation with a 2-bit counter.
  n64_vmux #(.FIFO_DEPTH(DEPTH), .UCNT_W(2)) dut_sat (
    .VCLK(VCLK), .nRST(rst_n), .pix(pix_b), .n15bit_mode_i(mode_i),
    .nDSYNC_o(nd_b), .D_o(d_b), .underrun_cnt_o(ucnt_b)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle = 0;
  logic        rst_seen = 1'b0;
  logic        drv_mode = 1'b1;
  int          blocked_cnt = 0;

  // Model state
  item_t       m_fifo[$];
  int          m_p;
  logic [24:0] m_cur;
  logic        m_cur_pix;
  logic        m_mode;
  int          m_ucnt, m_ucnt2;
  logic        m_pushed;

  exp_t        sb_q[$];
  item_t       src_q[$];
  logic [6:0]  red_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic item_t mk(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                               input logic [6:0] b, input logic md);
    item_t it;
    it.data = {s, r, g, b};
    it.mode = md;
    return it;
  endfunction

  // Predict the outputs of the coming edge and push them to the scoreboard.
  task automatic model_edge();
    exp_t       e;
    item_t      it;
    logic       ready_m;
    logic       push;
    logic [6:0] c;
    e.log_red = 1'b0;
    m_pushed  = 1'b0;
    if (!rst_n) begin
      m_p = 3; m_fifo.delete(); m_cur = BLANK; m_cur_pix = 1'b0;
      m_mode = 1'b1; m_ucnt = 0; m_ucnt2 = 0;
      e.nd = 1'b1; e.d = 7'h00; e.nd2 = 1'b1; e.d2 = 7'h00;
    end else begin
      ready_m = (m_fifo.size() < DEPTH);
      push    = pix_a.pix_valid_i && ready_m;
      if (m_p == 3) begin
        if (m_fifo.size() != 0) begin
          it = m_fifo.pop_front();
          if (!it.data[24] && m_cur[24]) m_mode = mode_i;
          m_cur = it.data; m_cur_pix = 1'b1;
        end else begin
          m_cur = BLANK; m_cur_pix = 1'b0;
          if (m_ucnt < 255) m_ucnt++;
        end
        if (m_ucnt2 < 3) m_ucnt2++;
        e.nd = 1'b0; e.d = {3'b000, m_cur[24:21]};
        e.nd2 = 1'b0; e.d2 = 7'h0F;
      end else begin
        case (m_p)
          0:       c = m_cur[20:14];
          1:       c = m_cur[13:7];
          default: c = m_cur[6:0];
        endcase
        e.nd = 1'b1; e.d = m_mode ? c : {c[6:2], 2'b00};
        e.nd2 = 1'b1; e.d2 = 7'h00;
        e.log_red = (m_p == 0) && m_cur_pix;
      end
      if (push) begin
        it.data = pix_a.pix_data_i; it.mode = drv_mode;
        m_fifo.push_back(it);
        m_pushed = 1'b1;
      end
      m_p = (m_p + 1) % 4;
    end
    e.ucnt = m_ucnt; e.ucnt2 = m_ucnt2;
    sb_q.push_back(e);
  endtask

  // One VCLK cycle: predict, clock, then compare #1 after the edge.
  task automatic step();
    exp_t e;
    logic ready_m;
    if (rst_n && m_p == 3 && m_fifo.size() != 0) mode_i = m_fifo[0].mode;
    ready_m = (m_fifo.size() < DEPTH);
    if (rst_seen) check("ready", pix_a.pix_ready_o, ready_m);
    if (rst_n && pix_a.pix_valid_i && !ready_m) blocked_cnt++;
    model_edge();
    @(posedge VCLK);
    #1;
    cycle++;
    e = sb_q.pop_front();
    check("nDSYNC", nd_a, e.nd);
    check("D", d_a, e.d);
    check("underrun", ucnt_a, e.ucnt);
    check("sat_underrun", ucnt_b, e.ucnt2);
    check("sat_nDSYNC", nd_b, e.nd2);
    check("sat_D", d_b, e.d2);
    if (e.log_red) red_log.push_back(d_a);
  endtask

  // Stream every queued item with valid held high, then let the last one finish.
  task automatic run_src();
    int guard = 0;
    while (m_p != 0 && guard < 8) begin step(); guard++; end
    while (src_q.size() != 0 && guard < 1000) begin
      pix_a.pix_valid_i = 1'b1;
      pix_a.pix_data_i  = src_q[0].data;
      drv_mode          = src_q[0].mode;
      step();
      guard++;
      if (m_pushed) src_q.delete(0);
    end
    pix_a.pix_valid_i = 1'b0;
    while ((m_fifo.size() != 0 || m_p != 3) && guard < 1000) begin step(); guard++; end
    check("src_timeout", (guard < 1000), 1'b1);
  endtask

  logic [6:0] t1_d [20] = '{7'h0F, 7'h00, 7'h00, 7'h00, 7'h0F, 7'h55, 7'h2A, 7'h7F,
                            7'h0F, 7'h00, 7'h00, 7'h00, 7'h0F, 7'h00, 7'h00, 7'h00,
                            7'h0F, 7'h00, 7'h00, 7'h00};
  int t1_u [20] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [6:0] exp_reds[$];
    logic [20:0] rgb;
    int ucnt_start;
    item_t it;

    rst_n = 1'b0; mode_i = 1'b1;
    pix_a.pix_valid_i = 1'b0; pix_a.pix_data_i = '0;
    pix_b.pix_valid_i = 1'b0; pix_b.pix_data_i = '0;

    // Reset state
    step();
    rst_seen = 1'b1;
    step();
    check("rst_nDSYNC", nd_a, 1'b1);
    check("rst_D", d_a, 7'h00);
    check("rst_underrun", ucnt_a, 8'd0);
    check("rst_ready", pix_a.pix_ready_o, 1'b1);

    // Single pixel pushed on the first (sync) edge: too late, goes out one slot later
    rst_n = 1'b1;
    pix_a.pix_valid_i = 1'b1; pix_a.pix_data_i = {4'hF, 7'h55, 7'h2A, 7'h7F}; drv_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      pix_a.pix_valid_i = 1'b0;
      check("single_D", d_a, t1_d[i]);
      check("single_nDSYNC", nd_a, (i % 4 == 0) ? 1'b0 : 1'b1);
      check("single_underrun", ucnt_a, t1_u[i]);
      if (i % 4 == 0) check("sat_seq", ucnt_b, (i == 0) ? 2'd1 : (i == 4) ? 2'd2 : 2'd3);
    end

    // Back-to-back stream of 16 pixels paced by ready
    while (m_p != 0) step();
    ucnt_start = m_ucnt;
    blocked_cnt = 0;
    red_log.delete();
    exp_reds.delete();
    for (int i = 0; i < 16; i++) begin
      rgb = 21'($urandom);
      src_q.push_back(mk(4'hF, rgb[20:14], rgb[13:7], rgb[6:0], 1'b1));
      exp_reds.push_back(rgb[20:14]);
    end
    run_src();
    check("stream_underrun", ucnt_a, ucnt_start);
    check("stream_blocked", blocked_cnt, 41);
    check("stream_count", red_log.size(), 16);
    for (int i = 0; i < 16 && i < red_log.size(); i++) check("stream_order", red_log[i], exp_reds[i]);

    // Full FIFO: third pixel held off until after the pop
    blocked_cnt = 0;
    red_log.delete();
    src_q.push_back(mk(4'hF, 7'h11, 7'h01, 7'h02, 1'b1));
    src_q.push_back(mk(4'hF, 7'h22, 7'h03, 7'h04, 1'b1));
    src_q.push_back(mk(4'hF, 7'h33, 7'h05, 7'h06, 1'b1));
    run_src();
    check("full_blocked", blocked_cnt, 2);
    check("full_count", red_log.size(), 3);
    if (red_log.size() == 3) begin
      check("full_order0", red_log[0], 7'h11);
      check("full_order1", red_log[1], 7'h22);
      check("full_order2", red_log[2], 7'h33);
    end

    // 15-bit mode switching at vsync falling edges only
    red_log.delete();
    src_q.push_back(mk(4'hF, 7'h7F, 7'h2B, 7'h7F, 1'b1)); run_src();
    src_q.push_back(mk(4'hF, 7'h7F, 7'h2B, 7'h7F, 1'b0)); run_src();
    src_q.push_back(mk(4'h7, 7'h7F, 7'h2B, 7'h7F, 1'b0));
    src_q.push_back(mk(4'h7, 7'h7F, 7'h2B, 7'h7F, 1'b1)); run_src();
    src_q.push_back(mk(4'hF, 7'h7F, 7'h2B, 7'h7F, 1'b1)); run_src();
    src_q.push_back(mk(4'h7, 7'h7F, 7'h2B, 7'h7F, 1'b1)); run_src();
    check("mode_count", red_log.size(), 6);
    if (red_log.size() == 6) begin
      check("mode_full_initial", red_log[0], 7'h7F);
      check("mode_midframe_ignored", red_log[1], 7'h7F);
      check("mode_15bit_at_vsync", red_log[2], 7'h7C);
      check("mode_vsync_held_low", red_log[3], 7'h7C);
      check("mode_no_frame", red_log[4], 7'h7C);
      check("mode_full_at_vsync", red_log[5], 7'h7F);
    end

    // Reset during the green phase with a second pixel still buffered
    pix_a.pix_valid_i = 1'b0;
    while (m_p != 0) step();
    pix_a.pix_valid_i = 1'b1; drv_mode = 1'b1;
    pix_a.pix_data_i = {4'hF, 7'h41, 7'h42, 7'h43};
    step();
    pix_a.pix_data_i = {4'hE, 7'h51, 7'h52, 7'h53};
    step();
    pix_a.pix_valid_i = 1'b0;
    step(); step(); step();
    check("pre_rst_phase", m_p, 1);
    rst_n = 1'b0;
    step();
    check("midrst_D", d_a, 7'h00);
    check("midrst_nDSYNC", nd_a, 1'b1);
    check("midrst_underrun", ucnt_a, 8'd0);
    check("midrst_ready", pix_a.pix_ready_o, 1'b1);
    rst_n = 1'b1;
    step();
    check("post_rst_D", d_a, 7'h0F);
    check("post_rst_nDSYNC", nd_a, 1'b0);
    step(); step(); step(); step();
    check("post_rst_flushed_D", d_a, 7'h0F);
    check("post_rst_underrun", ucnt_a, 8'd2);
    it = mk(4'h0, 7'h00, 7'h00, 7'h00, 1'b0);
    check("post_rst_model_empty", m_fifo.size(), it.data[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
